rx_intf_pkt_packer: RTL

RX_INTF_PKT_PACKER -- requirements
Module: rx_intf_pkt_packer

---
 rtl/rx_intf_pkt_packer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/rx_intf_pkt_packer.sv
// Packs 32-bit IQ samples into 64-bit words with optional TSF header, flush and zero padding.
// Optional header word enabled by defining RX_INTF_PKT_PACKER_TSF_HEADER_EN.
module rx_intf_pkt_packer #(
  parameter int C_M_AXIS_TDATA_WIDTH   = 64,
  parameter int MAX_BIT_NUM_DMA_SYMBOL = 14
) (
  input  logic                              M_AXIS_ACLK,
  input  logic                              M_AXIS_ARESETN,
  input  logic                              pkt_start,
  input  logic                              pkt_end,
  input  logic [31:0]                       sample_in,
  input  logic                              sample_in_valid,
  input  logic [63:0]                       tsf_val,
  input  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0] num_dma_symbol,
  input  logic                              FULLN_TO_ACC,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0]   DATA_TO_ACC,
  output logic                              DATA_TO_ACC_VALID,
  output logic                              start_1trans,
  output logic [15:0]                       drop_count,
  output logic                              busy_err
);

  // Write side: a word is "due" in a cycle when word_due is high; it is written only
  // if FULLN_TO_ACC is high, otherwise it is dropped. Either way the word counter advances.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
`ifdef RX_INTF_PKT_PACKER_TSF_HEADER_EN
    HEADER  = 2'd1,
`endif
    PAYLOAD = 2'd2,
    PAD     = 2'd3
  } state_t;

  state_t                              state_q, nxt_state;
  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   word_cnt_q;
  logic [MAX_BIT_NUM_DMA_SYMBOL-1:0]   last_idx_q;
  logic [31:0]                         half_q, half_d;
  logic                                half_vld_q, half_vld_d;
  logic                                end_pend_q, end_pend_d;
  logic                                word_due;
  logic [C_M_AXIS_TDATA_WIDTH-1:0]     word_data;
  logic                                last_word;
  logic                                end_now;
  logic                                start_d;
  logic                                pkt_accept;

`ifdef RX_INTF_PKT_PACKER_TSF_HEADER_EN
  logic [63:0] tsf_q;

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      tsf_q <= '0;
    end else if (pkt_accept) begin
      tsf_q <= tsf_val;
    end
  end
`else
  logic unused_tsf;
  assign unused_tsf = ^tsf_val;
`endif

  assign pkt_accept = (state_q == IDLE) && pkt_start;
  assign last_word  = (word_cnt_q == last_idx_q);

  always_comb begin
    nxt_state  = state_q;
    word_due   = 1'b0;
    word_data  = '0;
    half_d     = half_q;
    half_vld_d = half_vld_q;
    end_pend_d = end_pend_q;
    end_now    = 1'b0;
    case (state_q)
      IDLE: begin
        if (pkt_start) begin
          half_vld_d = 1'b0;
          end_pend_d = 1'b0;
`ifdef RX_INTF_PKT_PACKER_TSF_HEADER_EN
          nxt_state  = HEADER;
`else
          nxt_state  = PAYLOAD;
`endif
        end
      end
`ifdef RX_INTF_PKT_PACKER_TSF_HEADER_EN
      HEADER: begin
        word_due  = 1'b1;
        word_data = tsf_q;
        // A sample or end arriving alongside the header is held for the payload phase.
        if (sample_in_valid) begin
          half_d     = sample_in;
          half_vld_d = 1'b1;
        end
        end_pend_d = pkt_end;
        nxt_state  = last_word ? IDLE : PAYLOAD;
      end
`endif
      PAYLOAD: begin
        end_now    = pkt_end || end_pend_q;
        end_pend_d = 1'b0;
        // The sample is packed first; end handling then flushes any odd half-word.
        if (sample_in_valid) begin
          if (half_vld_q) begin
            word_due   = 1'b1;
            word_data  = {sample_in, half_q};
            half_vld_d = 1'b0;
          end else if (end_now) begin
            word_due  = 1'b1;
            word_data = {32'd0, sample_in};
          end else begin
            half_d     = sample_in;
            half_vld_d = 1'b1;
          end
        end else if (end_now && half_vld_q) begin
          word_due   = 1'b1;
          word_data  = {32'd0, half_q};
          half_vld_d = 1'b0;
        end
        if (word_due && last_word) begin
          nxt_state = IDLE;
        end else if (end_now) begin
          nxt_state = PAD;
        end
      end
      PAD: begin
        word_due  = 1'b1;
        word_data = '0;
        if (last_word) begin
          nxt_state = IDLE;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // start_1trans is high from the first payload-side cycle until the FSM is back in IDLE.
  always_comb begin
    start_d = (nxt_state == PAYLOAD) || (nxt_state == PAD);
`ifdef RX_INTF_PKT_PACKER_TSF_HEADER_EN
    if (state_q == HEADER) begin
      start_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      state_q    <= IDLE;
      word_cnt_q <= '0;
      last_idx_q <= '0;
      half_q     <= '0;
      half_vld_q <= 1'b0;
      end_pend_q <= 1'b0;
    end else begin
      state_q    <= nxt_state;
      half_q     <= half_d;
      half_vld_q <= half_vld_d;
      end_pend_q <= end_pend_d;
      if (pkt_accept) begin
        word_cnt_q <= '0;
        last_idx_q <= num_dma_symbol;
      end else if (word_due) begin
        word_cnt_q <= word_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
    if (!M_AXIS_ARESETN) begin
      DATA_TO_ACC       <= '0;
      DATA_TO_ACC_VALID <= 1'b0;
      start_1trans      <= 1'b0;
      drop_count        <= '0;
      busy_err          <= 1'b0;
    end else begin
      DATA_TO_ACC_VALID <= word_due && FULLN_TO_ACC;
      start_1trans      <= start_d;
      if (word_due && FULLN_TO_ACC) begin
        DATA_TO_ACC <= word_data;
      end
      if (word_due && !FULLN_TO_ACC && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
      if (pkt_start && (state_q != IDLE)) begin
        busy_err <= 1'b1;
      end
    end
  end

endmodule
